ray_normal_arbiter: RTL and testbench

- Shares one unified sphere/plane normal pipeline (fixed latency 3, no stall) between N_REQ shading requesters.
- Round-robin arbitration; at most one issue per cycle into the pipeline.
- Each issue is tagged with the requester index in a delay line matched to the pipeline latency; each result returns with the index of the requester that issued it.
- Provides halt/drain control so the frame sequencer can quiesce the normal stage.

---
 rtl/ray_normal_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ray_normal_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_normal_arbiter.sv
// Round-robin front end sharing one fixed-latency normal pipeline among N_REQ requesters,
// with result tagging and halt/drain control. Define NORMAL_ARB_PERF_EN for perf counters.
module ray_normal_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int PIPE_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0]      req_obj_type,
  input  logic [N_REQ*96-1:0]   req_plane_normal,
  input  logic [N_REQ*96-1:0]   req_sphere_center,
  input  logic [N_REQ*96-1:0]   req_hit_pos,
  output logic                  pipe_new_data,
  output logic                  pipe_obj_type,
  output logic [95:0]           pipe_plane_normal,
  output logic [95:0]           pipe_sphere_center,
  output logic [95:0]           pipe_hit_pos,
  input  logic                  pipe_output_valid,
  input  logic [95:0]           pipe_hit_normal,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [95:0]           resp_normal,
  input  logic                  halt,
  output logic                  idle,
  output logic                  err_orphan
`ifdef NORMAL_ARB_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stall
`endif
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t               state_q;
  logic                 idle_q;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      cand;
  logic [ID_W-1:0]      gnt_id;
  logic                 gnt_any;
  logic [N_REQ-1:0]     gnt_vec;

  logic                 new_data_q;
  logic                 obj_type_q;
  logic [95:0]          plane_normal_q;
  logic [95:0]          sphere_center_q;
  logic [95:0]          hit_pos_q;
  logic [ID_W-1:0]      issue_id_q;

  logic [PIPE_LAT-1:0]  tag_v_q;
  logic [ID_W-1:0]      tag_id_q [PIPE_LAT];
  logic [PIPE_LAT-1:0]  inflight;
  logic                 drain_done;

  logic                 resp_valid_q;
  logic [ID_W-1:0]      resp_id_q;
  logic [95:0]          resp_normal_q;
  logic                 err_orphan_q;

  // Scan from the pointer upward with wrap; first valid requester wins.
  always_comb begin
    gnt_vec = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (!rst && state_q == S_RUN && !halt) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = ID_W'((int'(ptr_q) + k) % N_REQ);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_id  = cand;
        end
      end
      if (gnt_any) gnt_vec[gnt_id] = 1'b1;
    end
  end

  // The last tag stage retires this cycle, so it does not block the drain.
  always_comb begin
    inflight             = tag_v_q;
    inflight[PIPE_LAT-1] = 1'b0;
    drain_done           = !new_data_q && (inflight == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      idle_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (halt) state_q <= S_DRAIN;
          idle_q <= 1'b0;
        end
        S_DRAIN: begin
          if (!halt) begin
            state_q <= S_RUN;
            idle_q  <= 1'b0;
          end else if (drain_done) begin
            state_q <= S_HALTED;
            idle_q  <= 1'b1;
          end
        end
        S_HALTED: begin
          if (!halt) begin
            state_q <= S_RUN;
            idle_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_RUN;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q           <= '0;
      new_data_q      <= 1'b0;
      obj_type_q      <= 1'b0;
      plane_normal_q  <= '0;
      sphere_center_q <= '0;
      hit_pos_q       <= '0;
      issue_id_q      <= '0;
      tag_v_q         <= '0;
      for (int k = 0; k < PIPE_LAT; k++) tag_id_q[k] <= '0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= '0;
      resp_normal_q   <= '0;
      err_orphan_q    <= 1'b0;
    end else begin
      new_data_q <= gnt_any;
      if (gnt_any) begin
        ptr_q           <= ID_W'((int'(gnt_id) + 1) % N_REQ);
        obj_type_q      <= req_obj_type[gnt_id];
        plane_normal_q  <= req_plane_normal[int'(gnt_id)*96 +: 96];
        sphere_center_q <= req_sphere_center[int'(gnt_id)*96 +: 96];
        hit_pos_q       <= req_hit_pos[int'(gnt_id)*96 +: 96];
        issue_id_q      <= gnt_id;
      end
      tag_v_q[0]  <= new_data_q;
      tag_id_q[0] <= issue_id_q;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
      resp_valid_q <= pipe_output_valid && tag_v_q[PIPE_LAT-1];
      if (pipe_output_valid && tag_v_q[PIPE_LAT-1]) begin
        resp_id_q     <= tag_id_q[PIPE_LAT-1];
        resp_normal_q <= pipe_hit_normal;
      end
      if (pipe_output_valid != tag_v_q[PIPE_LAT-1]) err_orphan_q <= 1'b1;
    end
  end

`ifdef NORMAL_ARB_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (gnt_any) perf_issued_q <= perf_issued_q + 32'd1;
      if ((|req_valid) && !gnt_any) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

  assign req_ready          = gnt_vec;
  assign pipe_new_data      = new_data_q;
  assign pipe_obj_type      = obj_type_q;
  assign pipe_plane_normal  = plane_normal_q;
  assign pipe_sphere_center = sphere_center_q;
  assign pipe_hit_pos       = hit_pos_q;
  assign resp_valid         = resp_valid_q;
  assign resp_id            = resp_id_q;
  assign resp_normal        = resp_normal_q;
  assign idle               = idle_q;
  assign err_orphan         = err_orphan_q;

endmodule

// File: tb/tb_ray_normal_arbiter.sv
// Scoreboard bench for ray_normal_arbiter: directed requests, a 3-cycle pipeline model,
// and a negedge monitor that checks grants and responses against queued expectations.
module tb_ray_normal_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_obj_type;
  logic [N*96-1:0] req_plane_normal;
  logic [N*96-1:0] req_sphere_center;
  logic [N*96-1:0] req_hit_pos;
  logic            pipe_new_data;
  logic            pipe_obj_type;
  logic [95:0]     pipe_plane_normal;
  logic [95:0]     pipe_sphere_center;
  logic [95:0]     pipe_hit_pos;
  logic            pipe_output_valid;
  logic [95:0]     pipe_hit_normal;
  logic            resp_valid;
  logic [W-1:0]    resp_id;
  logic [95:0]     resp_normal;
  logic            halt;
  logic            idle;
  logic            err_orphan;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          exp_gnt[$];
  int          exp_rid[$];
  logic [95:0] exp_rn[$];
  int          acc_cyc[$];
  logic [95:0] exp_norm [N];

  ray_normal_arbiter #(.N_REQ(N), .ID_W(W), .PIPE_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_obj_type(req_obj_type),
    .req_plane_normal(req_plane_normal), .req_sphere_center(req_sphere_center),
    .req_hit_pos(req_hit_pos),
    .pipe_new_data(pipe_new_data), .pipe_obj_type(pipe_obj_type),
    .pipe_plane_normal(pipe_plane_normal), .pipe_sphere_center(pipe_sphere_center),
    .pipe_hit_pos(pipe_hit_pos),
    .pipe_output_valid(pipe_output_valid), .pipe_hit_normal(pipe_hit_normal),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_normal(resp_normal),
    .halt(halt), .idle(idle), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [95:0] vec3(int x, int y, int z);
    return {z[31:0], y[31:0], x[31:0]};
  endfunction

  function automatic logic [95:0] vsub(logic [95:0] a, logic [95:0] b);
    logic [95:0] r;
    for (int l = 0; l < 3; l++) r[l*32 +: 32] = a[l*32 +: 32] - b[l*32 +: 32];
    return r;
  endfunction

  // Pipeline model: 3 cycles from new_data to output_valid; not reset, so in-flight work survives rst.
  logic        pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
  logic [95:0] pn0 = '0, pn1 = '0, pn2 = '0;
  logic        inj = 1'b0;
  always @(posedge clk) begin
    pv0 <= pipe_new_data;
    pn0 <= pipe_obj_type ? pipe_plane_normal : vsub(pipe_hit_pos, pipe_sphere_center);
    pv1 <= pv0; pn1 <= pn0;
    pv2 <= pv1; pn2 <= pn1;
  end
  assign pipe_output_valid = pv2 | inj;
  assign pipe_hit_normal   = pn2;

  task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic expect_grant(int id);
    exp_gnt.push_back(id);
    exp_rid.push_back(id);
    exp_rn.push_back(exp_norm[id]);
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_req_ready"}, 96'(req_ready), 96'd0);
    chk({nm, "_pipe_new_data"}, 96'(pipe_new_data), 96'd0);
    chk({nm, "_pipe_data"}, pipe_hit_pos | pipe_sphere_center | pipe_plane_normal | 96'(pipe_obj_type), 96'd0);
    chk({nm, "_resp"}, resp_normal | 96'(resp_id) | 96'(resp_valid), 96'd0);
    chk({nm, "_err_idle"}, 96'({err_orphan, idle}), 96'd0);
  endtask

  task automatic wait_drain(string nm);
    int n = 0;
    while ((exp_rid.size() != 0 || exp_gnt.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (exp_rid.size() != 0 || exp_gnt.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d_pending required=0", nm, exp_rid.size() + exp_gnt.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every presented grant and response is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) begin
        checks++;
        if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
          failures++;
          $display("FAIL grant_shape actual=%b required=onehot_within_%b", req_ready, req_valid);
        end
        if (exp_gnt.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant actual=%b required=none", req_ready);
        end else begin
          int g;
          g = exp_gnt.pop_front();
          chk("grant_id", 96'(req_ready), 96'(1) << g);
        end
        acc_cyc.push_back(cyc);
      end
      if (resp_valid) begin
        if (exp_rid.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual=id%0d required=no_resp", resp_id);
        end else begin
          int id;
          logic [95:0] rn;
          id = exp_rid.pop_front();
          rn = exp_rn.pop_front();
          chk("resp_id", 96'(resp_id), 96'(id));
          chk("resp_normal", resp_normal, rn);
          if (acc_cyc.size() != 0) chk("resp_latency", 96'(cyc - acc_cyc.pop_front()), 96'd5);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = '0; halt = 1'b0;
    req_obj_type = 4'b1010;
    req_hit_pos[0*96 +: 96]       = vec3(5, 0, 0);
    req_sphere_center[0*96 +: 96] = vec3(1, 0, 0);
    req_plane_normal[0*96 +: 96]  = vec3(1, 2, 3);
    req_hit_pos[1*96 +: 96]       = vec3(9, 9, 9);
    req_sphere_center[1*96 +: 96] = vec3(1, 1, 1);
    req_plane_normal[1*96 +: 96]  = vec3(0, 1, 0);
    req_hit_pos[2*96 +: 96]       = vec3(7, 8, 9);
    req_sphere_center[2*96 +: 96] = vec3(1, 2, 3);
    req_plane_normal[2*96 +: 96]  = vec3(3, 3, 3);
    req_hit_pos[3*96 +: 96]       = vec3(2, 2, 2);
    req_sphere_center[3*96 +: 96] = vec3(0, 0, 0);
    req_plane_normal[3*96 +: 96]  = vec3(0, 0, 7);
    exp_norm[0] = vec3(4, 0, 0);
    exp_norm[1] = vec3(0, 1, 0);
    exp_norm[2] = vec3(6, 6, 6);
    exp_norm[3] = vec3(0, 0, 7);

    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single sphere request from requester 0.
    @(posedge clk); #1;
    expect_grant(0);
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    chk("issue_strobe", 96'(pipe_new_data), 96'd1);
    chk("issue_hit_pos", pipe_hit_pos, vec3(5, 0, 0));
    wait_drain("single");

    // Fresh reset, then all four valid: strict rotation.
    rst = 1'b1; #2 rst = 1'b0;
    @(posedge clk); #1;
    expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3);
    expect_grant(0); expect_grant(1);
    req_valid = 4'b1111;
    repeat (6) @(posedge clk);
    #1 req_valid = '0;
    wait_drain("rotate");

    // Pointer is 2; only 1 and 3 request.
    expect_grant(3); expect_grant(1); expect_grant(3);
    req_valid = 4'b1010;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    wait_drain("sparse");

    // Halt with three in flight, then resume.
    expect_grant(0); expect_grant(1); expect_grant(2);
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    #1 halt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halt_idle_low", 96'(idle), 96'd0);
      chk("halt_no_grant", 96'(req_ready), 96'd0);
    end
    @(negedge clk);
    chk("halt_idle_high", 96'(idle), 96'd1);
    @(posedge clk); #1 halt = 1'b0;
    expect_grant(3);
    @(negedge clk);
    chk("resume_wait", 96'(req_ready), 96'd0);
    @(posedge clk); #1;
    chk("resume_idle_low", 96'(idle), 96'd0);
    @(posedge clk); #1 req_valid = '0;
    wait_drain("halt");

    // Orphan result with an empty tag line.
    chk("orphan_before", 96'(err_orphan), 96'd0);
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    chk("orphan_set", 96'(err_orphan), 96'd1);
    chk("orphan_no_resp", 96'(resp_valid), 96'd0);
    repeat (3) @(posedge clk);
    #1 chk("orphan_sticky", 96'(err_orphan), 96'd1);

    // Asynchronous reset in the middle of a burst.
    expect_grant(0); expect_grant(1); expect_grant(2);
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    req_valid = 4'b1100;
    exp_rid.delete(); exp_rn.delete(); acc_cyc.delete();
    #1 chk_all_zero("async_rst");
    expect_grant(2);
    #1 rst = 1'b0;
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    chk("rst_orphan", 96'(err_orphan), 96'd1);
    wait_drain("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
